mac_sequencer: RTL and testbench



---
 rtl/mac_seq_pkg.sv | 21 ++
 rtl/mac_sequencer.sv | 112 +++++++++++
 tb/tb_mac_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared widths and FSM encodings for the MAC job sequencer.
// The tap limit keeps MAX_TAPS * 255 below 2^OUT_W, so no saturation.
package mac_seq_pkg;

    localparam int MAX_TAPS = 16;
    localparam int ADDR_W   = 4;
    localparam int LEN_W    = 5;
    localparam int OUT_W    = 12;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CLEAR = 2'd1;
    localparam state_t S_RUN   = 2'd2;
    localparam state_t S_OUT   = 2'd3;

    function automatic logic len_ok(input logic [LEN_W-1:0] l);
        return (l != '0) && (l <= LEN_W'(MAX_TAPS));
    endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Runs one dot-product job: clears the MAC, streams buffer reads,
// enables accumulation one cycle behind each read, then holds the result.
module mac_sequencer
    import mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] win_base,
    input  logic [ADDR_W-1:0] filt_base,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] win_addr,
    output logic [ADDR_W-1:0] filt_addr,
    output logic              mac_reg_en,
    output logic              mac_clean,
    input  logic [OUT_W-1:0]  mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wb_q, wb_d;
    logic [ADDR_W-1:0] fb_q, fb_d;
    logic              rd_en_q;
    logic [ADDR_W-1:0] off;

    // Address offset wraps modulo the buffer depth.
    assign off = cnt_q[ADDR_W-1:0];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wb_d       = wb_q;
        fb_d       = fb_q;
        busy       = 1'b1;
        rd_en      = 1'b0;
        win_addr   = '0;
        filt_addr  = '0;
        mac_reg_en = 1'b0;
        mac_clean  = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start && len_ok(len)) begin
                    len_d   = len;
                    wb_d    = win_base;
                    fb_d    = filt_base;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clean = 1'b1;
                rd_en     = 1'b1;
                win_addr  = wb_q;
                filt_addr = fb_q;
                cnt_d     = LEN_W'(1);
                state_d   = S_RUN;
            end
            S_RUN: begin
                rd_en      = (cnt_q < len_q);
                win_addr   = wb_q + off;
                filt_addr  = fb_q + off;
                mac_reg_en = rd_en_q;
                if (rd_en) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
                // Final accumulate happens in this same cycle.
                if ((cnt_q == len_q) && rd_en_q) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = out_valid ? mac_result : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wb_q    <= '0;
            fb_q    <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            fb_q    <= fb_d;
            rd_en_q <= rd_en;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with behavioural buffers and MAC.
// Expected results come from a plain dot-product model over the buffers.
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] filt_base;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] filt_addr;
    logic              mac_reg_en;
    logic              mac_clean;
    logic [OUT_W-1:0]  mac_result;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    mac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .win_base   (win_base),
        .filt_base  (filt_base),
        .busy       (busy),
        .rd_en      (rd_en),
        .win_addr   (win_addr),
        .filt_addr  (filt_addr),
        .mac_reg_en (mac_reg_en),
        .mac_clean  (mac_clean),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffers and the 8x8 MAC (upper product byte accumulated)
    logic [7:0]  win_mem [16];
    logic [7:0]  filt_mem[16];
    logic [7:0]  win_q, filt_q;
    logic [15:0] prod;
    logic [11:0] acc;

    assign prod       = {8'd0, win_q} * {8'd0, filt_q};
    assign mac_result = acc;

    always @(posedge clk) begin
        if (rd_en) begin
            win_q  <= win_mem[win_addr];
            filt_q <= filt_mem[filt_addr];
        end
        if (rst)             acc <= '0;
        else if (mac_clean)  acc <= '0;
        else if (mac_reg_en) acc <= acc + {4'd0, prod[15:8]};
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        int data;
        int vcyc;
        int len;
        int wb;
        int fb;
    } exp_t;

    exp_t exp_q[$];

    function automatic int model_sum(input int l, input int wb, input int fb);
        int s = 0;
        for (int i = 0; i < l; i++) begin
            s += (int'(win_mem[(wb + i) % 16]) *
                  int'(filt_mem[(fb + i) % 16])) / 256;
        end
        return s;
    endfunction

    // Monitor: samples on the falling edge
    int         wa[$];
    int         fa[$];
    int         regen_n, runs, clean_n;
    logic       prev_rst   = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_regen = 1'b0;
    logic [11:0] prev_data = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("reset_outputs_zero",
                      32'({busy, rd_en, mac_reg_en, mac_clean, out_valid,
                           win_addr, filt_addr, out_data}), 32'd0);
            end
            prev_rst = rst;
            if (rst) begin
                exp_q.delete();
                wa.delete();
                fa.delete();
                regen_n    = 0;
                runs       = 0;
                clean_n    = 0;
                prev_valid = 1'b0;
                prev_regen = 1'b0;
            end else begin
                if (mac_clean && mac_reg_en)
                    check("clean_regen_exclusive", 32'(mac_clean & mac_reg_en), 32'd0);
                if (rd_en) begin
                    wa.push_back(int'(win_addr));
                    fa.push_back(int'(filt_addr));
                end
                if (mac_reg_en) begin
                    regen_n++;
                    if (!prev_regen) runs++;
                end
                prev_regen = mac_reg_en;
                if (mac_clean) clean_n++;
                if (out_valid) begin
                    check("busy_in_out", 32'(busy), 32'd1);
                    if (prev_valid)
                        check("out_data_stable", 32'(out_data), 32'(prev_data));
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_out_valid");
                    end else begin
                        if (!prev_valid)
                            check("valid_latency", 32'(cyc), 32'(exp_q[0].vcyc));
                        if (out_ready) begin
                            e = exp_q.pop_front();
                            check("out_data", 32'(out_data), 32'(e.data));
                            check("regen_count", 32'(regen_n), 32'(e.len));
                            check("regen_one_run", 32'(runs), 32'd1);
                            check("clean_count", 32'(clean_n), 32'd1);
                            check("read_count", 32'(wa.size()), 32'(e.len));
                            for (int i = 0; i < e.len && i < wa.size(); i++) begin
                                check("win_addr_seq", 32'(wa[i]), 32'((e.wb + i) % 16));
                                check("filt_addr_seq", 32'(fa[i]), 32'((e.fb + i) % 16));
                            end
                            wa.delete();
                            fa.delete();
                            regen_n = 0;
                            runs    = 0;
                            clean_n = 0;
                        end
                    end
                end else if (out_data != '0) begin
                    check("out_data_zero_when_invalid", 32'(out_data), 32'd0);
                end
                prev_valid = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // Stimulus: drives 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            win_mem[i]  = 8'($urandom);
            filt_mem[i] = 8'($urandom);
        end
    endtask

    task automatic issue(input int l, input int wb, input int fb);
        exp_t e;
        e.data = model_sum(l, wb, fb);
        e.vcyc = cyc + l + 2;
        e.len  = l;
        e.wb   = wb;
        e.fb   = fb;
        exp_q.push_back(e);
        start     = 1'b1;
        len       = LEN_W'(l);
        win_base  = ADDR_W'(wb);
        filt_base = ADDR_W'(fb);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
    endtask

    task automatic run_job(input int l, input int wb, input int fb,
                           input int stall, input bit stall_start,
                           input bit hs_start);
        int t = 0;
        issue(l, wb, fb);
        while (!out_valid && t < 60) begin
            tick();
            t++;
        end
        if (!out_valid) begin
            fail_now("timeout_waiting_out_valid");
            do_reset();
        end else begin
            for (int k = 0; k < stall; k++) begin
                check("busy_while_stalled", 32'(busy), 32'd1);
                if (stall_start) begin
                    start = 1'($urandom);
                    len   = LEN_W'(1 + $urandom_range(0, 15));
                end
                tick();
            end
            start     = hs_start;
            len       = LEN_W'(1 + $urandom_range(0, 15));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            start     = 1'b0;
            check("idle_after_handshake", 32'(busy), 32'd0);
        end
    endtask

    task automatic try_bad_len(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bad_len_busy", 32'(busy), 32'd0);
            check("bad_len_rd_en", 32'(rd_en), 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        win_base  = '0;
        filt_base = '0;
        out_ready = 1'b0;
        fill_random();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single tap, 0x80 * 0x80
        win_mem[0]  = 8'h80;
        filt_mem[0] = 8'h80;
        run_job(1, 0, 0, 0, 1'b0, 1'b0);

        // Full-length job of all ones
        for (int i = 0; i < 16; i++) begin
            win_mem[i]  = 8'hFF;
            filt_mem[i] = 8'hFF;
        end
        run_job(16, 0, 0, 0, 1'b0, 1'b0);

        // Window address wrap
        fill_random();
        run_job(4, 14, 0, 0, 1'b0, 1'b0);

        // Stalled output with start pulses, then start on handshake
        fill_random();
        run_job(6, 3, 9, 5, 1'b1, 1'b1);

        try_bad_len(0);
        try_bad_len(17);
        try_bad_len(31);

        // Back-to-back job must not include the prior sum
        run_job(5, 7, 2, 1, 1'b0, 1'b0);

        // Reset in the middle of a long job, then a short one
        fill_random();
        issue(16, 0, 0);
        repeat (4) tick();
        do_reset();
        run_job(2, 1, 5, 0, 1'b0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            fill_random();
            run_job($urandom_range(1, 16), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 4),
                    1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (5) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
